fd_config_arbiter: RTL and testbench
====================================

# fd_config_arbiter

- Shares one FrequencyDivider between NUM_REQ requesters that each want a different divide ratio.
- Grants requests round-robin and sequences the divider's configuration: stop it, load `Din` with a `ConfigDiv` pulse, wait for settling, then re-enable it.
- Tracks the currently loaded ratio and acknowledges each requester when its ratio is in effect.
- Sits between the clock-management register block and the divider.

## Interface

Parameters:
- NUM_REQ, default 4: number of requesters (2..8).
- DATA_W, default 32: ratio width; matches divider `Din`.
- SETTLE_CYCLES, default 2: cycles `Enable` stays low after the load (1..15).

Ports:
- Clk  in  1  single clock; all logic on posedge.
- ResetN  in  1  asynchronous, active-low reset. The top level ties the divider `Reset` to ~ResetN.
- RunEn  in  1  global run request for the divider.
- Req  in  NUM_REQ  level request, one bit per requester; held until Ack.
- ReqDiv  in  NUM_REQ*DATA_W  requested ratios; requester i owns bits [i*DATA_W +: DATA_W].
- Ack  out  NUM_REQ  one-cycle pulse to the served requester.
- Err  out  1  one-cycle pulse, coincident with Ack, when the served ratio was 0 (rejected).
- Busy  out  1  high whenever state != IDLE.
- GrantIdx  out  $clog2(NUM_REQ)  index of the last granted requester.
- CurDiv  out  DATA_W  ratio currently loaded in the divider.
- Din  out  DATA_W  to divider `Din`.
- ConfigDiv  out  1  to divider `ConfigDiv`.
- Enable  out  1  to divider `Enable`.

## Operation

- All outputs are registered.
- Reset values: Ack=0, Err=0, Busy=0, GrantIdx=0, CurDiv=1, Din=1, ConfigDiv=0, Enable=0, pointer=0, state=IDLE.
- FSM states: IDLE, STOP, LOAD, SETTLE.
- IDLE:
  - Enable <= RunEn; ConfigDiv <= 0.
  - If any Req bit is high, select the first set bit searching upward from pointer, wrapping.
  - Latch its index to GrantIdx and its ReqDiv to an internal ratio register.
  - pointer <= (index+1) mod NUM_REQ.
  - If the ratio is 0: Ack[index] and Err pulse; stay in IDLE; divider untouched.
  - Otherwise: Enable <= 0; go to STOP.
- STOP: Enable=0. Din <= ratio; ConfigDiv <= 1. Go to LOAD.
- LOAD:
  - ConfigDiv high for exactly this cycle; the divider samples it with Enable=0.
  - Next: ConfigDiv <= 0; CurDiv <= ratio; settle counter <= SETTLE_CYCLES-1. Go to SETTLE.
- SETTLE:
  - Enable=0; counter decrements.
  - At 0: Ack[GrantIdx] <= 1; Enable <= RunEn; go to IDLE.
- Ack is single-cycle. A Req still high in the cycle after its Ack counts as a new request.
- Pointer rotation bounds any waiting requester to NUM_REQ-1 grants of others.
- ReqDiv is sampled once, at grant. Later changes are ignored until the next grant.
- RunEn changes are honoured only in IDLE, one cycle late. Enable is forced 0 in every other state.
- Din holds its last loaded value outside LOAD.
- ResetN low at any point returns all outputs to reset values immediately and aborts the sequence; no Ack is issued.

## Timing

- Edge 0: IDLE samples Req.
- Edge 1: state=LOAD; Din valid; ConfigDiv=1.
- Edge 2: state=SETTLE.
- Edge 2+SETTLE_CYCLES: Ack high for the following cycle; Enable restored.
- Grant-to-Ack latency: 2+SETTLE_CYCLES edges (4 at default).
- Enable is low for 2+SETTLE_CYCLES cycles per reconfiguration.
- Zero-ratio rejection: Ack and Err high the cycle after edge 0.
- Back-to-back requests: the next grant is evaluated on the edge after Ack, so one IDLE cycle separates sequences.
- Simultaneous requests: exactly one grant per IDLE evaluation.

## Configuration

- FDC_SKIP_SAME_EN defined: in IDLE, a nonzero ratio equal to CurDiv is acknowledged immediately, with the same timing as the zero-ratio path. Err=0, Enable is not dropped, pointer still advances.
- Not defined: every nonzero request runs the full STOP/LOAD/SETTLE sequence, even if the ratio is unchanged.

## Test plan

- Reset, then release with RunEn=1 and no Req → all outputs at reset values during reset; Enable=1 one cycle after release; CurDiv=1.
- Req[2]=1 with ReqDiv[2]=6 → ConfigDiv pulse with Din=6; Enable low 4 cycles; Ack[2] 4 edges after grant; CurDiv=6.
- Req=4'b1111 held, each requester dropping Req after its own Ack → granted in order 0,1,2,3 from pointer 0; pointer ends at 0.
- Req[1] with ReqDiv[1]=0 → Ack[1] and Err together one cycle after the sampling edge; no ConfigDiv; CurDiv unchanged.
- Assert ResetN low during SETTLE → Enable=0, CurDiv=1, Busy=0 immediately; no Ack; a subsequent request completes normally.
- FDC_SKIP_SAME_EN defined, CurDiv=6, request ratio 6 → immediate Ack, Err=0, Enable stays 1. Without the macro → full sequence.

Source files
------------

// File: rtl/fd_config_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module : fd_config_arbiter_if
// Bundles the requester handshake and the divider-facing configuration bus.
// Revision: 1.0
// ============================================================================
interface fd_config_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic                      RunEn;
  logic [NUM_REQ-1:0]        Req;
  logic [NUM_REQ*DATA_W-1:0] ReqDiv;
  logic [NUM_REQ-1:0]        Ack;
  logic                      Err;
  logic                      Busy;
  logic [IDX_W-1:0]          GrantIdx;
  logic [DATA_W-1:0]         CurDiv;
  logic [DATA_W-1:0]         Din;
  logic                      ConfigDiv;
  logic                      Enable;

  modport master (
    output RunEn, Req, ReqDiv,
    input  Ack, Err, Busy, GrantIdx, CurDiv, Din, ConfigDiv, Enable
  );

  modport slave (
    input  RunEn, Req, ReqDiv,
    output Ack, Err, Busy, GrantIdx, CurDiv, Din, ConfigDiv, Enable
  );
endinterface
`default_nettype wire

// File: rtl/fd_config_arbiter.sv
`default_nettype none
// ============================================================================
// Module : fd_config_arbiter
// Round-robin arbiter sequencing stop/load/settle/enable of a shared divider.
// Option : FDC_SKIP_SAME_EN acknowledges an unchanged nonzero ratio at once.
// Revision: 1.0
// ============================================================================
module fd_config_arbiter #(
  parameter int NUM_REQ       = 4,
  parameter int DATA_W        = 32,
  parameter int SETTLE_CYCLES = 2
) (
  input  wire logic          Clk,
  input  wire logic          ResetN,
  fd_config_arbiter_if.slave bus
);
  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_STOP   = 2'd1,
    S_LOAD   = 2'd2,
    S_SETTLE = 2'd3
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [IDX_W-1:0]   r_ptr, w_ptr;
  logic [DATA_W-1:0]  r_ratio, w_ratio;
  logic [CNT_W-1:0]   r_cnt, w_cnt;
  logic [NUM_REQ-1:0] r_ack, w_ack;
  logic               r_err, w_err;
  logic               r_busy;
  logic [IDX_W-1:0]   r_grant, w_grant;
  logic [DATA_W-1:0]  r_cur, w_cur;
  logic [DATA_W-1:0]  r_din, w_din;
  logic               r_cfg, w_cfg;
  logic               r_en, w_en;

  logic               w_found;
  logic [IDX_W-1:0]   w_idx;
  logic [IDX_W-1:0]   w_ptr_inc;
  logic [DATA_W-1:0]  w_sel_div;
  logic               w_same;

  // First requester at or above the pointer, wrapping around.
  always_comb begin : p_pick
    w_found = 1'b0;
    w_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!w_found && bus.Req[(int'(r_ptr) + k) % NUM_REQ]) begin
        w_found = 1'b1;
        w_idx   = IDX_W'((int'(r_ptr) + k) % NUM_REQ);
      end
    end
  end

  assign w_ptr_inc = (w_idx == IDX_W'(NUM_REQ - 1)) ? '0 : w_idx + IDX_W'(1);
  assign w_sel_div = bus.ReqDiv[int'(w_idx)*DATA_W +: DATA_W];

`ifdef FDC_SKIP_SAME_EN
  assign w_same = (w_sel_div == r_cur);
`else
  assign w_same = 1'b0;
`endif

  always_comb begin : p_next
    w_state_nxt = r_state;
    w_ptr       = r_ptr;
    w_ratio     = r_ratio;
    w_cnt       = r_cnt;
    w_ack       = '0;
    w_err       = 1'b0;
    w_grant     = r_grant;
    w_cur       = r_cur;
    w_din       = r_din;
    w_cfg       = 1'b0;
    w_en        = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_en = bus.RunEn;
        if (w_found) begin
          w_grant = w_idx;
          w_ratio = w_sel_div;
          w_ptr   = w_ptr_inc;
          if (w_sel_div == '0) begin
            w_ack = NUM_REQ'(1) << w_idx;
            w_err = 1'b1;
          end else if (w_same) begin
            w_ack = NUM_REQ'(1) << w_idx;
          end else begin
            w_en        = 1'b0;
            w_state_nxt = S_STOP;
          end
        end
      end
      S_STOP: begin
        w_din       = r_ratio;
        w_cfg       = 1'b1;
        w_state_nxt = S_LOAD;
      end
      S_LOAD: begin
        w_cur       = r_ratio;
        w_cnt       = CNT_W'(SETTLE_CYCLES - 1);
        w_state_nxt = S_SETTLE;
      end
      S_SETTLE: begin
        if (r_cnt == '0) begin
          w_ack       = NUM_REQ'(1) << r_grant;
          w_en        = bus.RunEn;
          w_state_nxt = S_IDLE;
        end else begin
          w_cnt = r_cnt - CNT_W'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge ResetN) begin : p_regs
    if (!ResetN) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_ratio <= '0;
      r_cnt   <= '0;
      r_ack   <= '0;
      r_err   <= 1'b0;
      r_busy  <= 1'b0;
      r_grant <= '0;
      r_cur   <= DATA_W'(1);
      r_din   <= DATA_W'(1);
      r_cfg   <= 1'b0;
      r_en    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr;
      r_ratio <= w_ratio;
      r_cnt   <= w_cnt;
      r_ack   <= w_ack;
      r_err   <= w_err;
      r_busy  <= (w_state_nxt != S_IDLE);
      r_grant <= w_grant;
      r_cur   <= w_cur;
      r_din   <= w_din;
      r_cfg   <= w_cfg;
      r_en    <= w_en;
    end
  end

  assign bus.Ack       = r_ack;
  assign bus.Err       = r_err;
  assign bus.Busy      = r_busy;
  assign bus.GrantIdx  = r_grant;
  assign bus.CurDiv    = r_cur;
  assign bus.Din       = r_din;
  assign bus.ConfigDiv = r_cfg;
  assign bus.Enable    = r_en;
endmodule
`default_nettype wire

// File: tb/tb_fd_config_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_fd_config_arbiter
// Randomized self-checking bench with a transaction-level arbitration model.
// Revision: 1.0
// ============================================================================
module tb_fd_config_arbiter;
  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 32;
  localparam int SETTLE  = 2;
  localparam int IDX_W   = $clog2(NUM_REQ);
  // Negedge samples from stimulus to the Ack sample for a full reconfiguration.
  localparam int SEQ_LAT = 3 + SETTLE;

  logic Clk = 1'b0;
  logic ResetN;
  always #5 Clk = ~Clk;

  fd_config_arbiter_if #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) bus ();

  fd_config_arbiter #(
    .NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .SETTLE_CYCLES(SETTLE)
  ) dut (
    .Clk(Clk), .ResetN(ResetN), .bus(bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int model_ptr;
  logic [DATA_W-1:0] model_cur;

  int                 o_cycles, o_en_low, o_busy, o_cfg_cnt;
  bit                 o_got;
  logic [NUM_REQ-1:0] o_ack;
  logic               o_err;
  logic [DATA_W-1:0]  o_din_cfg;

  function automatic int rr_pick(input logic [NUM_REQ-1:0] req, input int ptr);
    for (int k = 0; k < NUM_REQ; k++)
      if (req[(ptr + k) % NUM_REQ]) return (ptr + k) % NUM_REQ;
    return -1;
  endfunction

  task automatic set_div(input int i, input logic [DATA_W-1:0] v);
    bus.ReqDiv[i*DATA_W +: DATA_W] = v;
  endtask

  // Observes until an Ack appears; the served requester drops its Req at once.
  task automatic wait_ack(input int budget);
    o_got = 0; o_cycles = 0; o_en_low = 0; o_busy = 0; o_cfg_cnt = 0;
    o_ack = '0; o_err = 1'b0; o_din_cfg = '0;
    while (!o_got && o_cycles < budget) begin
      @(negedge Clk);
      o_cycles++;
      if (bus.ConfigDiv) begin o_cfg_cnt++; o_din_cfg = bus.Din; end
      if (bus.Ack != '0) begin
        o_got = 1; o_ack = bus.Ack; o_err = bus.Err;
        bus.Req = bus.Req & ~bus.Ack;
      end else begin
        if (!bus.Enable) o_en_low++;
        if (bus.Busy) o_busy++;
      end
    end
  endtask

  task automatic test_reset;
    ResetN = 1'b0; bus.RunEn = 1'b1; bus.Req = '0; bus.ReqDiv = '0;
    repeat (3) @(negedge Clk);
    n_checks++; if (bus.Ack !== '0) begin n_fail++; $display("FAIL rst_ack got=%b exp=0", bus.Ack); end
    n_checks++; if (bus.Err !== 1'b0 || bus.Busy !== 1'b0 || bus.ConfigDiv !== 1'b0 || bus.Enable !== 1'b0) begin
      n_fail++; $display("FAIL rst_flags err/busy/cfg/en got=%b%b%b%b exp=0000", bus.Err, bus.Busy, bus.ConfigDiv, bus.Enable); end
    n_checks++; if (bus.GrantIdx !== '0) begin n_fail++; $display("FAIL rst_grant got=%0d exp=0", bus.GrantIdx); end
    n_checks++; if (bus.CurDiv !== 1 || bus.Din !== 1) begin n_fail++; $display("FAIL rst_div cur=%0d din=%0d exp=1", bus.CurDiv, bus.Din); end
    ResetN = 1'b1;
    @(negedge Clk);
    n_checks++; if (bus.Enable !== 1'b1) begin n_fail++; $display("FAIL rst_release_en got=%b exp=1", bus.Enable); end
    n_checks++; if (bus.CurDiv !== 1) begin n_fail++; $display("FAIL rst_release_cur got=%0d exp=1", bus.CurDiv); end
    model_ptr = 0; model_cur = 1;
  endtask

  task automatic test_round_robin;
    int g;
    for (int i = 0; i < NUM_REQ; i++) set_div(i, DATA_W'(10 + i));
    bus.Req = '1;
    for (int n = 0; n < NUM_REQ; n++) begin
      g = rr_pick(bus.Req, model_ptr);
      wait_ack(40);
      n_checks++; if (o_cycles !== SEQ_LAT || o_ack !== (NUM_REQ'(1) << g)) begin
        n_fail++; $display("FAIL rr_ack n=%0d got lat=%0d ack=%b exp lat=%0d idx=%0d", n, o_cycles, o_ack, SEQ_LAT, g); end
      n_checks++; if (bus.GrantIdx !== IDX_W'(g) || bus.CurDiv !== DATA_W'(10 + g)) begin
        n_fail++; $display("FAIL rr_state got grant=%0d cur=%0d exp grant=%0d cur=%0d", bus.GrantIdx, bus.CurDiv, g, 10 + g); end
      model_ptr = (g + 1) % NUM_REQ; model_cur = DATA_W'(10 + g);
    end
  endtask

  task automatic test_single;
    bit en0, busy0;
    set_div(2, 6); bus.Req = 4'b0100;
    @(negedge Clk);
    en0 = !bus.Enable; busy0 = bus.Busy;
    set_div(2, 9);
    wait_ack(20);
    n_checks++; if (o_cycles + 1 !== SEQ_LAT || o_ack !== 4'b0100 || o_err !== 1'b0) begin
      n_fail++; $display("FAIL single_ack got lat=%0d ack=%b err=%b exp lat=%0d ack=0100 err=0", o_cycles + 1, o_ack, o_err, SEQ_LAT); end
    n_checks++; if (o_cfg_cnt !== 1 || o_din_cfg !== 6) begin
      n_fail++; $display("FAIL single_cfg got pulses=%0d din=%0d exp 1 pulse din=6", o_cfg_cnt, o_din_cfg); end
    n_checks++; if (o_en_low + int'(en0) !== 2 + SETTLE || o_busy + int'(busy0) !== 2 + SETTLE) begin
      n_fail++; $display("FAIL single_enlow got en_low=%0d busy=%0d exp %0d", o_en_low + int'(en0), o_busy + int'(busy0), 2 + SETTLE); end
    n_checks++; if (bus.CurDiv !== 6 || bus.Din !== 6 || bus.Enable !== 1'b1 || bus.GrantIdx !== 2'd2) begin
      n_fail++; $display("FAIL single_end got cur=%0d din=%0d en=%b grant=%0d exp 6/6/1/2", bus.CurDiv, bus.Din, bus.Enable, bus.GrantIdx); end
    model_ptr = 3; model_cur = 6;
  endtask

  task automatic test_zero;
    set_div(1, 0); bus.Req = 4'b0010;
    wait_ack(10);
    n_checks++; if (o_cycles !== 1 || o_ack !== 4'b0010 || o_err !== 1'b1) begin
      n_fail++; $display("FAIL zero_ack got lat=%0d ack=%b err=%b exp lat=1 ack=0010 err=1", o_cycles, o_ack, o_err); end
    n_checks++; if (o_cfg_cnt !== 0 || bus.CurDiv !== model_cur || bus.Enable !== 1'b1) begin
      n_fail++; $display("FAIL zero_state got cfg=%0d cur=%0d en=%b exp 0/%0d/1", o_cfg_cnt, bus.CurDiv, bus.Enable, model_cur); end
    model_ptr = 2;
  endtask

  task automatic test_skip_same;
    set_div(2, model_cur); bus.Req = 4'b0100;
    wait_ack(20);
`ifdef FDC_SKIP_SAME_EN
    n_checks++; if (o_cycles !== 1 || o_err !== 1'b0 || o_en_low !== 0 || o_cfg_cnt !== 0) begin
      n_fail++; $display("FAIL same_skip got lat=%0d err=%b en_low=%0d cfg=%0d exp 1/0/0/0", o_cycles, o_err, o_en_low, o_cfg_cnt); end
`else
    n_checks++; if (o_cycles !== SEQ_LAT || o_err !== 1'b0 || o_cfg_cnt !== 1) begin
      n_fail++; $display("FAIL same_full got lat=%0d err=%b cfg=%0d exp %0d/0/1", o_cycles, o_err, o_cfg_cnt, SEQ_LAT); end
`endif
    n_checks++; if (o_ack !== 4'b0100 || bus.Enable !== 1'b1 || bus.CurDiv !== model_cur) begin
      n_fail++; $display("FAIL same_state got ack=%b en=%b cur=%0d exp 0100/1/%0d", o_ack, bus.Enable, bus.CurDiv, model_cur); end
    model_ptr = 3;
  endtask

  task automatic test_reset_mid;
    bit saw_ack;
    set_div(3, 7); bus.Req = 4'b1000;
    repeat (3) @(negedge Clk);
    ResetN = 1'b0;
    #1;
    n_checks++; if (bus.Enable !== 1'b0 || bus.CurDiv !== 1 || bus.Busy !== 1'b0 || bus.Ack !== '0) begin
      n_fail++; $display("FAIL midrst got en=%b cur=%0d busy=%b ack=%b exp 0/1/0/0", bus.Enable, bus.CurDiv, bus.Busy, bus.Ack); end
    bus.Req = '0;
    saw_ack = 0;
    repeat (3) begin @(negedge Clk); if (bus.Ack != '0) saw_ack = 1; end
    ResetN = 1'b1;
    @(negedge Clk); if (bus.Ack != '0) saw_ack = 1;
    n_checks++; if (saw_ack !== 1'b0) begin n_fail++; $display("FAIL midrst_noack got ack_seen=1 exp 0"); end
    model_ptr = 0; model_cur = 1;
    bus.Req = 4'b1000;
    wait_ack(20);
    n_checks++; if (o_cycles !== SEQ_LAT || o_ack !== 4'b1000 || bus.CurDiv !== 7) begin
      n_fail++; $display("FAIL midrst_after got lat=%0d ack=%b cur=%0d exp %0d/1000/7", o_cycles, o_ack, bus.CurDiv, SEQ_LAT); end
    model_ptr = 0; model_cur = 7;
  endtask

  task automatic test_random;
    int g, exp_lat; bit full, zero;
    logic [DATA_W-1:0] d;
    for (int n = 0; n < 40; n++) begin
      bus.RunEn = 1'($urandom_range(0, 1));
      for (int i = 0; i < NUM_REQ; i++) begin
        case ($urandom_range(0, 5))
          0: set_div(i, 0);
          1: set_div(i, model_cur);
          default: set_div(i, DATA_W'($urandom_range(1, 50)));
        endcase
      end
      bus.Req = NUM_REQ'($urandom_range(1, (1 << NUM_REQ) - 1));
      g = rr_pick(bus.Req, model_ptr);
      d = bus.ReqDiv[g*DATA_W +: DATA_W];
      zero = (d == 0);
`ifdef FDC_SKIP_SAME_EN
      full = !zero && (d != model_cur);
`else
      full = !zero;
`endif
      exp_lat = full ? SEQ_LAT : 1;
      wait_ack(30);
      n_checks++; if (o_cycles !== exp_lat || o_ack !== (NUM_REQ'(1) << g) || o_err !== zero) begin
        n_fail++; $display("FAIL rand_ack n=%0d got lat=%0d ack=%b err=%b exp lat=%0d idx=%0d err=%b", n, o_cycles, o_ack, o_err, exp_lat, g, zero); end
      if (full) model_cur = d;
      n_checks++; if (bus.GrantIdx !== IDX_W'(g) || bus.CurDiv !== model_cur || bus.Enable !== bus.RunEn || o_cfg_cnt !== int'(full)) begin
        n_fail++; $display("FAIL rand_state n=%0d got grant=%0d cur=%0d en=%b cfg=%0d exp %0d/%0d/%b/%0d", n, bus.GrantIdx, bus.CurDiv, bus.Enable, o_cfg_cnt, g, model_cur, bus.RunEn, int'(full)); end
      model_ptr = (g + 1) % NUM_REQ;
    end
    bus.Req = '0;
  endtask

  initial begin
    test_reset;
    test_round_robin;
    test_single;
    test_zero;
    test_skip_same;
    test_reset_mid;
    test_random;
    repeat (2) @(negedge Clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
